rotation_line_parser: RTL

//  Upstream stage of the dial zero-counter datapath. Consumes the puzzle input as a
//  raw ASCII byte stream ("R45\n", "L123\n", ...). Emits one registered rotation

---
 rtl/rotation_line_parser_if.sv | 38 +++
 rtl/rotation_line_parser.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rotation_line_parser_if.sv
// Handshake bundle between the byte source, the rotation line parser and the
// downstream BCD converter / accumulator chain.
//   slave  : parser view (consumes bytes, produces records)
//   master : environment view (produces bytes, consumes records)
interface rotation_line_parser_if #(
    parameter int VAL_W = 10
);
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [VAL_W-1:0] rot_val;
    logic             rot_dir;
    logic             rot_valid;
    logic             rot_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        output in_ready,
        output rot_val,
        output rot_dir,
        output rot_valid,
        input  rot_ready
    );

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        input  in_ready,
        input  rot_val,
        input  rot_dir,
        input  rot_valid,
        output rot_ready
    );
endinterface

// File: rtl/rotation_line_parser.sv
// Rotation line parser: turns an ASCII stream of lines such as "R45\n" or
// "L123\n" into registered (magnitude, direction) records with valid/ready
// flow control on both sides.
// Optional feature macro: PARSER_ERR_EN adds err_pulse / err_count outputs.
//
// state  | meaning
// IDLE   | between lines; waits for 'R'/'L', ignores '\n', '\r', ' '
// DIR    | direction latched; waits for the first digit
// DIGITS | accumulating decimal magnitude; '\n' or in_last emits
// SKIP   | malformed line; discards bytes up to '\n' or in_last
module rotation_line_parser #(
    parameter int VAL_W = 10,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rotation_line_parser_if.slave bus,
    output logic [CNT_W-1:0]     line_count,
    output logic                 busy
`ifdef PARSER_ERR_EN
    ,
    output logic                 err_pulse,
    output logic [CNT_W-1:0]     err_count
`endif
);

    localparam int ACC_W = VAL_W + 4;
    localparam logic [ACC_W-1:0] ACC_MAX = {4'b0000, {VAL_W{1'b1}}};

    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIR,
        ST_DIGITS,
        ST_SKIP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [ACC_W-1:0] acc_mul;
    logic [ACC_W-1:0] acc_sum;
    logic             dir;
    logic             dir_nxt;
    logic             in_ready;
    logic             accept;
    logic             is_digit;
    logic             is_term;
    logic             ovf;
    logic             emit;
    logic             err_cand;
    logic [3:0]       digit;
    logic [VAL_W-1:0] emit_val;
    logic [VAL_W-1:0] rot_val_q;
    logic             rot_dir_q;
    logic             rot_valid_q;
    logic [CNT_W-1:0] line_cnt_q;

    // A byte may only be taken when its possible record has a free slot.
    assign in_ready = !(rot_valid_q && !bus.rot_ready);
    assign accept   = bus.in_valid && in_ready;

    assign digit    = bus.in_data[3:0];
    assign is_digit = (bus.in_data >= CH_0) && (bus.in_data <= CH_9);
    assign is_term  = (bus.in_data == CH_LF) || bus.in_last;

    // acc*10 + digit, saturating at the largest magnitude the record can hold.
    // acc never exceeds ACC_MAX, so the product always fits in ACC_W bits.
    assign acc_mul  = (acc << 3) + (acc << 1) + {{(ACC_W-4){1'b0}}, digit};
    assign ovf      = (acc_mul > ACC_MAX);
    assign acc_sum  = ovf ? ACC_MAX : acc_mul;

    // A digit terminator (in_last on a digit) emits the freshly accumulated value.
    assign emit_val = is_digit ? acc_sum[VAL_W-1:0] : acc[VAL_W-1:0];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, accumulator update, emit and error decode for an accepted byte.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        dir_nxt   = dir;
        emit      = 1'b0;
        err_cand  = 1'b0;
        if (accept) begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.in_last) begin
                        state_nxt = ST_IDLE;
                    end else if ((bus.in_data == CH_R) || (bus.in_data == CH_L)) begin
                        state_nxt = ST_DIR;
                        dir_nxt   = (bus.in_data == CH_R);
                        acc_nxt   = '0;
                    end else if ((bus.in_data == CH_LF) || (bus.in_data == CH_CR) ||
                                 (bus.in_data == CH_SP)) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_SKIP;
                        err_cand  = 1'b1;
                    end
                end
                ST_DIR, ST_DIGITS: begin
                    if (is_digit) begin
                        acc_nxt  = acc_sum;
                        err_cand = ovf;
                        if (bus.in_last) begin
                            emit      = 1'b1;
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_DIGITS;
                        end
                    end else if (is_term) begin
                        state_nxt = ST_IDLE;
                        if (state == ST_DIGITS) begin
                            emit = 1'b1;
                        end else begin
                            err_cand = 1'b1;
                        end
                    end else if ((state == ST_DIGITS) && (bus.in_data == CH_CR)) begin
                        state_nxt = ST_DIGITS;
                    end else begin
                        state_nxt = ST_SKIP;
                        err_cand  = 1'b1;
                    end
                end
                ST_SKIP: begin
                    if (is_term) begin
                        state_nxt = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Line datapath: magnitude accumulator and latched direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            dir <= 1'b0;
        end else begin
            acc <= acc_nxt;
            dir <= dir_nxt;
        end
    end

    // Output record slot and line counter; a same-edge emit reloads the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            rot_val_q   <= '0;
            rot_dir_q   <= 1'b0;
            rot_valid_q <= 1'b0;
            line_cnt_q  <= '0;
        end else if (emit) begin
            rot_val_q   <= emit_val;
            rot_dir_q   <= dir;
            rot_valid_q <= 1'b1;
            line_cnt_q  <= line_cnt_q + CNT_W'(1);
        end else if (bus.rot_ready) begin
            rot_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.rot_val   = rot_val_q;
    assign bus.rot_dir   = rot_dir_q;
    assign bus.rot_valid = rot_valid_q;
    assign line_count    = line_cnt_q;
    assign busy          = (state != ST_IDLE) || rot_valid_q;

`ifdef PARSER_ERR_EN
    logic line_err;

    // Error pulse/counter; line_err limits reporting to the first error of a line.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_err  <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= err_cand && !line_err;
            if (err_cand && !line_err) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (accept) begin
                line_err <= (state_nxt == ST_IDLE) ? 1'b0 : (line_err || err_cand);
            end
        end
    end
`else
    logic unused_err;
    assign unused_err = err_cand;
`endif

endmodule
